out_mem_streamer: RTL and testbench

OUT_MEM_STREAMER -- requirements
Module: out_mem_streamer

---
 rtl/dsa_pkg.sv | 22 ++
 rtl/stream_skid_fifo.sv | 55 +++++
 rtl/out_mem_streamer.sv | 148 ++++++++++++++
 tb/tb_out_mem_streamer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dsa_pkg.sv
// rtl/dsa_pkg.sv - shared DSA types, default widths and the pixel-count helper
package dsa_pkg;

    localparam int DSA_AW = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } stream_state_t;

    // Image pixel count, clipped to the size of an aw-bit address space
    function automatic logic [31:0] sat_total(input logic [15:0] w, input logic [15:0] h,
                                              input int aw);
        logic [31:0] prod;
        logic [31:0] lim;
        prod = 32'(w) * 32'(h);
        lim  = 32'd1 << aw;
        return (prod > lim) ? lim : prod;
    endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// rtl/stream_skid_fifo.sv - small pixel FIFO carrying 8-bit data plus a last flag
module stream_skid_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [7:0]                 push_data,
    input  logic                       push_last,
    input  logic                       pop,
    output logic                       valid,
    output logic [7:0]                 head_data,
    output logic                       head_last,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [8:0]    store_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [CW-1:0] count_q;
    logic          do_pop;

    assign valid     = (count_q != '0);
    assign do_pop    = pop & valid;
    assign head_data = valid ? store_q[rd_q][7:0] : 8'd0;
    assign head_last = valid & store_q[rd_q][8];
    assign count     = count_q;

    // Storage write; contents need no reset because the head is masked when empty
    always_ff @(posedge clk) begin
        if (push) begin
            store_q[wr_q] <= {push_last, push_data};
        end
    end

    // Pointer and occupancy update
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + PW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/out_mem_streamer.sv
// rtl/out_mem_streamer.sv - drains an output image from BRAM as a pixel stream
module out_mem_streamer
    import dsa_pkg::*;
#(
    parameter int AW     = DSA_AW,
    parameter int FIFO_D = 4
) (
    input  logic          clk_50,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] i_base,
    input  logic [15:0]   i_out_w,
    input  logic [15:0]   i_out_h,
    output logic [AW-1:0] mem_raddr,
    input  logic [7:0]    mem_rdata,
    output logic          m_valid,
    output logic [7:0]    m_data,
    output logic          m_last,
    input  logic          m_ready,
    output logic          busy,
    output logic          done,
    output logic [31:0]   o_px_sent,
    output logic [31:0]   o_stall_cycles
);
    localparam int TW = AW + 1;
    localparam int CW = $clog2(FIFO_D) + 1;

    stream_state_t state_q;
    stream_state_t state_d;
    logic [TW-1:0] total_d;
    logic [TW-1:0] total_q;
    logic [TW-1:0] issued_q;
    logic          p1_q, p1_last_q;
    logic          p2_q, p2_last_q;
    logic          zero_done_q;
    logic [CW-1:0] fifo_count;
    logic          pop;
    logic          accept_start;
    logic          room;
    logic          next_is_last;
    logic          issue_run;

    assign total_d      = TW'(sat_total(i_out_w, i_out_h, AW));
    assign pop          = m_valid & m_ready;
    assign accept_start = start & (state_q == ST_IDLE);
    // p1: address on the BRAM port, p2: data on mem_rdata; both still owe a FIFO slot
    assign room         = (int'(fifo_count) + int'(p1_q) + int'(p2_q) - int'(pop)) < FIFO_D;
    assign next_is_last = (issued_q + TW'(1)) == total_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = zero_done_q | ((state_q == ST_DRAIN) & pop & m_last);

    // State register
    always_ff @(posedge clk_50) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and read-issue decision; read 0 goes out with the start itself
    always_comb begin
        state_d   = state_q;
        issue_run = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && total_d != '0) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (issued_q == total_q) begin
                    state_d = ST_DRAIN;
                end else if (room) begin
                    issue_run = 1'b1;
                    if (next_is_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && m_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read address generation and the two-stage in-flight tracker
    always_ff @(posedge clk_50) begin
        if (rst) begin
            total_q     <= '0;
            issued_q    <= '0;
            mem_raddr   <= '0;
            p1_q        <= 1'b0;
            p1_last_q   <= 1'b0;
            p2_q        <= 1'b0;
            p2_last_q   <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            zero_done_q <= accept_start && (total_d == '0);
            p2_q        <= p1_q;
            p2_last_q   <= p1_last_q;
            p1_q        <= 1'b0;
            p1_last_q   <= 1'b0;
            if (accept_start) begin
                total_q <= total_d;
                if (total_d != '0) begin
                    mem_raddr <= i_base;
                    issued_q  <= TW'(1);
                    p1_q      <= 1'b1;
                    p1_last_q <= (total_d == TW'(1));
                end
            end else if (issue_run) begin
                mem_raddr <= mem_raddr + AW'(1);
                issued_q  <= issued_q + TW'(1);
                p1_q      <= 1'b1;
                p1_last_q <= next_is_last;
            end
        end
    end

    // Performance counters, cleared by each accepted start
    always_ff @(posedge clk_50) begin
        if (rst || accept_start) begin
            o_px_sent      <= '0;
            o_stall_cycles <= '0;
        end else begin
            o_px_sent      <= o_px_sent + 32'(pop);
            o_stall_cycles <= o_stall_cycles + 32'(m_valid & ~m_ready);
        end
    end

    stream_skid_fifo #(.DEPTH(FIFO_D)) u_fifo (
        .clk       (clk_50),
        .rst       (rst),
        .push      (p2_q),
        .push_data (mem_rdata),
        .push_last (p2_last_q),
        .pop       (pop),
        .valid     (m_valid),
        .head_data (m_data),
        .head_last (m_last),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_out_mem_streamer.sv
// tb/tb_out_mem_streamer.sv - scoreboard bench for out_mem_streamer
module tb_out_mem_streamer;
    localparam int AW = 12;
    localparam int MEM_N = 4096;

    logic          clk_50;
    logic          rst;
    logic          start;
    logic [AW-1:0] i_base;
    logic [15:0]   i_out_w;
    logic [15:0]   i_out_h;
    logic [AW-1:0] mem_raddr;
    logic [7:0]    mem_rdata;
    logic          m_valid;
    logic [7:0]    m_data;
    logic          m_last;
    logic          m_ready;
    logic          busy;
    logic          done;
    logic [31:0]   o_px_sent;
    logic [31:0]   o_stall_cycles;

    out_mem_streamer #(.AW(AW), .FIFO_D(4)) dut (
        .clk_50         (clk_50),
        .rst            (rst),
        .start          (start),
        .i_base         (i_base),
        .i_out_w        (i_out_w),
        .i_out_h        (i_out_h),
        .mem_raddr      (mem_raddr),
        .mem_rdata      (mem_rdata),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_last         (m_last),
        .m_ready        (m_ready),
        .busy           (busy),
        .done           (done),
        .o_px_sent      (o_px_sent),
        .o_stall_cycles (o_stall_cycles)
    );

    initial begin
        clk_50 = 1'b0;
        forever #10 clk_50 = ~clk_50;
    end

    // Behavioural BRAM with one cycle of read latency
    logic [7:0] mem [MEM_N];
    always @(posedge clk_50) mem_rdata <= mem[mem_raddr];

    // Sink: 0 = always ready, 1 = random 50%, 2 = never ready
    int ready_mode;
    always @(posedge clk_50) begin
        #1;
        if (ready_mode == 1)      m_ready = 1'($urandom_range(0, 1));
        else if (ready_mode == 2) m_ready = 1'b0;
        else                      m_ready = 1'b1;
    end

    logic [8:0] sb [$];
    int n_checks, n_pass;
    int beats_total, stall_total, done_total, busy_total, valid_total;
    int s_beats, s_stall, s_done, s_busy, s_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic monitor_loop();
        logic [8:0] e;
        forever begin
            @(negedge clk_50);
            if (m_valid && m_ready) begin
                beats_total++;
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL beat_excess: got beat data %0h, expected no beat", m_data);
                end else begin
                    e = sb.pop_front();
                    check("beat_data", m_data, e[7:0]);
                    check("beat_last", m_last, e[8]);
                end
            end
            if (m_valid && !m_ready) stall_total++;
            if (done)    done_total++;
            if (busy)    busy_total++;
            if (m_valid) valid_total++;
            if (rst)     sb.delete();
        end
    endtask

    // Reference: beat k carries mem[(base+k) mod 4096], count clipped to 4096
    task automatic arm_start(input int base, input int w, input int h);
        int n;
        n = w * h;
        if (n > MEM_N) n = MEM_N;
        for (int k = 0; k < n; k++)
            sb.push_back({(k == n - 1) ? 1'b1 : 1'b0, mem[(base + k) % MEM_N]});
        s_beats = beats_total; s_stall = stall_total; s_done = done_total;
        s_busy = busy_total;   s_valid = valid_total;
        i_base = AW'(base); i_out_w = 16'(w); i_out_h = 16'(h);
        start = 1'b1;
    endtask

    task automatic do_start(input int base, input int w, input int h);
        arm_start(base, w, h);
        @(posedge clk_50); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk_50);
            if (done) seen = 1'b1;
        end
        check(name, seen, 1);
        repeat (2) @(posedge clk_50);
        #1;
    endtask

    task automatic finish_checks(input string tag, input int exp_beats);
        check({tag, "_beats"},    beats_total - s_beats, exp_beats);
        check({tag, "_px_sent"},  o_px_sent, exp_beats);
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_done_cnt"}, done_total - s_done, 1);
        check({tag, "_stall"},    o_stall_cycles, stall_total - s_stall);
    endtask

    initial begin
        int base;
        bit hit;
        n_checks = 0; n_pass = 0;
        beats_total = 0; stall_total = 0; done_total = 0; busy_total = 0; valid_total = 0;
        for (int a = 0; a < MEM_N; a++) mem[a] = 8'($urandom);
        ready_mode = 0;
        rst = 1'b1; start = 1'b0; i_base = '0; i_out_w = '0; i_out_h = '0;
        fork
            monitor_loop();
        join_none
        repeat (3) @(posedge clk_50);
        #1 rst = 1'b0;
        @(negedge clk_50);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_mem_raddr", mem_raddr, 0);
        check("rst_px_sent", o_px_sent, 0);
        check("rst_stall", o_stall_cycles, 0);
        @(posedge clk_50); #1;

        // 4x4 from base 0 with the sink always ready
        do_start(0, 4, 4);
        @(negedge clk_50); check("lat_cycle1_valid", m_valid, 0);
        @(negedge clk_50); check("lat_cycle2_valid", m_valid, 0);
        @(negedge clk_50); check("lat_cycle3_valid", m_valid, 1);
        wait_done("t1_done_seen", 100);
        finish_checks("t1", 16);
        check("t1_stall_zero", o_stall_cycles, 0);

        // Address wrap at the top of the memory
        mem[12'hFFE] = 8'hA0; mem[12'hFFF] = 8'hA1; mem[0] = 8'hA2; mem[1] = 8'hA3;
        do_start(12'hFFE, 4, 1);
        wait_done("t2_done_seen", 100);
        finish_checks("t2", 4);
        check("t2_raddr_hold", mem_raddr, 1);

        // 8x8 with a randomly stalling sink
        ready_mode = 1;
        base = int'($urandom_range(0, MEM_N - 1));
        do_start(base, 8, 8);
        wait_done("t3_done_seen", 2000);
        finish_checks("t3", 64);
        ready_mode = 0;
        @(posedge clk_50); #1;

        // Empty image: immediate done, nothing else
        do_start(7, 0, 5);
        @(negedge clk_50); check("t4_done_next", done, 1);
        repeat (6) @(posedge clk_50);
        #1;
        check("t4_busy_never", busy_total - s_busy, 0);
        check("t4_valid_never", valid_total - s_valid, 0);
        check("t4_done_cnt", done_total - s_done, 1);

        // Reset in the middle of an 8x8 drain, then restart right after reset
        do_start(0, 8, 8);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk_50);
            if (beats_total - s_beats >= 10) hit = 1'b1;
        end
        check("t5_reached_beat10", hit, 1);
        @(posedge clk_50); #1 rst = 1'b1;
        @(posedge clk_50); #1 rst = 1'b0;
        arm_start(100, 2, 2);
        @(negedge clk_50);
        check("t5_valid_after_rst", m_valid, 0);
        check("t5_px_after_rst", o_px_sent, 0);
        check("t5_stall_after_rst", o_stall_cycles, 0);
        check("t5_busy_after_rst", busy, 0);
        @(posedge clk_50); #1 start = 1'b0;
        wait_done("t5_done_seen", 100);
        finish_checks("t5", 4);

        // A second start while running must be ignored
        do_start(32, 4, 4);
        @(posedge clk_50); #1;
        i_base = 12'h123; i_out_w = 16'd2; i_out_h = 16'd2; start = 1'b1;
        @(posedge clk_50); #1 start = 1'b0;
        wait_done("t6_done_seen", 100);
        finish_checks("t6", 16);

        // Oversized image clipped to the whole address space
        base = int'($urandom_range(0, MEM_N - 1));
        do_start(base, 100, 100);
        wait_done("t7_done_seen", 6000);
        finish_checks("t7", MEM_N);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
